video_timing_ctrl: RTL and testbench

Raster sequencer for the DVI transmit path: generates hsync/vsync/data-enable timing in the pixel clock domain, and issues per-pixel fetch requests with coordinates to the upstream pixel source (frame buffer / game renderer). It returns the fetched RGB888 pixel aligned to that timing, ready to drive the transmitter's `video_din`/`video_hsync`/`video_vsync`/`video_de` inputs. Frame starts and stops are gated by `enable` at frame boundaries only, so the sink never sees a truncated frame.

---
 rtl/video_timing_ctrl_if.sv | 31 +++
 rtl/video_timing_ctrl.sv | 162 ++++++++++++++++
 tb/tb_video_timing_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_ctrl_if
// Purpose  : Pixel fetch bus and DVI transmitter timing bundle.
// Revision : 1.0
// ============================================================================
interface video_timing_ctrl_if;
   logic        pixel_req;
   logic [11:0] pixel_x;
   logic [11:0] pixel_y;
   logic        line_start;
   logic        frame_start;
   logic [23:0] pixel_data;
   logic [23:0] video_din;
   logic        video_hsync;
   logic        video_vsync;
   logic        video_de;

   modport master (
      output pixel_req, pixel_x, pixel_y, line_start, frame_start,
      output video_din, video_hsync, video_vsync, video_de,
      input  pixel_data
   );

   modport slave (
      input  pixel_req, pixel_x, pixel_y, line_start, frame_start,
      input  video_din, video_hsync, video_vsync, video_de,
      output pixel_data
   );
endinterface
`default_nettype wire

// File: rtl/video_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_ctrl
// Purpose  : Raster sequencer producing fetch requests and aligned DVI timing.
// Revision : 1.0
// ============================================================================
module video_timing_ctrl #(
   parameter int H_SYNC  = 96,
   parameter int H_BACK  = 48,
   parameter int H_DISP  = 640,
   parameter int H_FRONT = 16,
   parameter int V_SYNC  = 2,
   parameter int V_BACK  = 33,
   parameter int V_DISP  = 480,
   parameter int V_FRONT = 10,
   parameter bit HS_POL  = 1'b0,
   parameter bit VS_POL  = 1'b0
) (
   input  logic                pclk,
   input  logic                reset_n,
   input  logic                enable,
   video_timing_ctrl_if.master vif
);

   localparam int          c_H_TOTAL  = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam int          c_V_TOTAL  = V_SYNC + V_BACK + V_DISP + V_FRONT;
   localparam logic [11:0] c_H_LAST   = 12'(c_H_TOTAL - 1);
   localparam logic [11:0] c_V_LAST   = 12'(c_V_TOTAL - 1);
   localparam logic [11:0] c_H_OFS    = 12'(H_SYNC + H_BACK);
   localparam logic [11:0] c_V_OFS    = 12'(V_SYNC + V_BACK);
   localparam logic [12:0] c_H_SYNC_E = 13'(H_SYNC);
   localparam logic [12:0] c_V_SYNC_E = 13'(V_SYNC);
   localparam logic [12:0] c_H_ACT_S  = 13'(H_SYNC + H_BACK);
   localparam logic [12:0] c_V_ACT_S  = 13'(V_SYNC + V_BACK);
   localparam logic [12:0] c_H_ACT_E  = 13'(H_SYNC + H_BACK + H_DISP);
   localparam logic [12:0] c_V_ACT_E  = 13'(V_SYNC + V_BACK + V_DISP);

   localparam logic [0:0]  c_IDLE = 1'b0;
   localparam logic [0:0]  c_RUN  = 1'b1;

   logic [0:0]  r_state;
   logic [0:0]  w_state_nxt;
   logic        w_run;
   logic [11:0] r_h_cnt;
   logic [11:0] r_v_cnt;
   logic        w_h_last;
   logic        w_v_last;
   logic        w_h_sync;
   logic        w_v_sync;
   logic        w_de;

   // request-side stage (t+1)
   logic        r_pixel_req;
   logic [11:0] r_pixel_x;
   logic [11:0] r_pixel_y;
   logic        r_line_start;
   logic        r_frame_start;
   logic        r_hs1;
   logic        r_vs1;
   // alignment stage (t+2) and video stage (t+3)
   logic        r_de2;
   logic        r_hs2;
   logic        r_vs2;
   logic        r_video_de;
   logic        r_video_hsync;
   logic        r_video_vsync;
   logic [23:0] r_video_din;

   assign w_h_last = (r_h_cnt == c_H_LAST);
   assign w_v_last = (r_v_cnt == c_V_LAST);
   assign w_h_sync = ({1'b0, r_h_cnt} < c_H_SYNC_E);
   assign w_v_sync = ({1'b0, r_v_cnt} < c_V_SYNC_E);
   assign w_de     = ({1'b0, r_h_cnt} >= c_H_ACT_S) && ({1'b0, r_h_cnt} < c_H_ACT_E) &&
                     ({1'b0, r_v_cnt} >= c_V_ACT_S) && ({1'b0, r_v_cnt} < c_V_ACT_E);

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) r_state <= c_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Leaving RUN is only allowed on the last pixel of a frame.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (enable) w_state_nxt = c_RUN;
         c_RUN:   if (w_h_last && w_v_last && !enable) w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   always_comb begin
      w_run = (r_state == c_RUN);
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         r_h_cnt <= 12'd0;
         r_v_cnt <= 12'd0;
      end else if (!w_run) begin
         r_h_cnt <= 12'd0;
         r_v_cnt <= 12'd0;
      end else if (w_h_last) begin
         r_h_cnt <= 12'd0;
         r_v_cnt <= w_v_last ? 12'd0 : r_v_cnt + 12'd1;
      end else begin
         r_h_cnt <= r_h_cnt + 12'd1;
      end
   end

   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         r_pixel_req   <= 1'b0;
         r_pixel_x     <= 12'd0;
         r_pixel_y     <= 12'd0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_hs1         <= 1'b0;
         r_vs1         <= 1'b0;
      end else begin
         r_pixel_req   <= w_run && w_de;
         r_pixel_x     <= (w_run && w_de) ? (r_h_cnt - c_H_OFS) : 12'd0;
         r_pixel_y     <= (w_run && w_de) ? (r_v_cnt - c_V_OFS) : 12'd0;
         r_line_start  <= w_run && (r_h_cnt == 12'd0);
         r_frame_start <= w_run && (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
         r_hs1         <= w_run && w_h_sync;
         r_vs1         <= w_run && w_v_sync;
      end
   end

   // The requester returns data one cycle after pixel_req; stage 2 waits for it.
   always_ff @(posedge pclk or negedge reset_n) begin
      if (!reset_n) begin
         r_de2         <= 1'b0;
         r_hs2         <= 1'b0;
         r_vs2         <= 1'b0;
         r_video_de    <= 1'b0;
         r_video_hsync <= ~HS_POL;
         r_video_vsync <= ~VS_POL;
         r_video_din   <= 24'h000000;
      end else begin
         r_de2         <= r_pixel_req;
         r_hs2         <= r_hs1;
         r_vs2         <= r_vs1;
         r_video_de    <= r_de2;
         r_video_hsync <= r_hs2 ? HS_POL : ~HS_POL;
         r_video_vsync <= r_vs2 ? VS_POL : ~VS_POL;
         r_video_din   <= r_de2 ? vif.pixel_data : 24'h000000;
      end
   end

   assign vif.pixel_req   = r_pixel_req;
   assign vif.pixel_x     = r_pixel_x;
   assign vif.pixel_y     = r_pixel_y;
   assign vif.line_start  = r_line_start;
   assign vif.frame_start = r_frame_start;
   assign vif.video_de    = r_video_de;
   assign vif.video_hsync = r_video_hsync;
   assign vif.video_vsync = r_video_vsync;
   assign vif.video_din   = r_video_din;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timing_ctrl
// Purpose  : Directed self-checking bench for video_timing_ctrl.
// Revision : 1.0
// ============================================================================
module tb_video_timing_ctrl;

   logic pclk = 1'b0;
   logic reset_n;
   logic enable;
   logic en_def;
   int   tests = 0;
   int   fails = 0;

   always #5 pclk = ~pclk;

   video_timing_ctrl_if vif ();
   video_timing_ctrl_if vif_def ();

   video_timing_ctrl #(
      .H_SYNC(2), .H_BACK(2), .H_DISP(4), .H_FRONT(2),
      .V_SYNC(1), .V_BACK(1), .V_DISP(3), .V_FRONT(1),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) u_dut (
      .pclk(pclk), .reset_n(reset_n), .enable(enable), .vif(vif)
   );

   video_timing_ctrl u_dut_def (
      .pclk(pclk), .reset_n(reset_n), .enable(en_def), .vif(vif_def)
   );

   // Requester with one cycle latency; junk outside requests exercises the output mask.
   always @(posedge pclk)
      vif.pixel_data <= vif.pixel_req ? {4'h0, vif.pixel_y[7:0], vif.pixel_x} : 24'hA5C33C;

   initial vif_def.pixel_data = 24'h123456;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // n = cycles since the enabling edge; limit = counter cycles spent in RUN.
   task automatic check_cycle(input int n, input int limit);
      int          i, h, v;
      logic        run, req, ede, ehs, evs;
      logic [11:0] ex, ey;
      logic [23:0] edin;
      i   = n - 2;
      h   = i % 10;
      v   = (i / 10) % 6;
      run = (i >= 0) && (i < limit);
      req = run && (h >= 4) && (h < 8) && (v >= 2) && (v < 5);
      ex  = req ? 12'(h - 4) : 12'd0;
      ey  = req ? 12'(v - 2) : 12'd0;
      check($sformatf("req@%0d", n), 32'(vif.pixel_req), 32'(req));
      check($sformatf("x@%0d", n), 32'(vif.pixel_x), 32'(ex));
      check($sformatf("y@%0d", n), 32'(vif.pixel_y), 32'(ey));
      check($sformatf("ls@%0d", n), 32'(vif.line_start), 32'(run && (h == 0)));
      check($sformatf("fs@%0d", n), 32'(vif.frame_start), 32'(run && (h == 0) && (v == 0)));
      i    = n - 4;
      h    = i % 10;
      v    = (i / 10) % 6;
      run  = (i >= 0) && (i < limit);
      ede  = run && (h >= 4) && (h < 8) && (v >= 2) && (v < 5);
      ehs  = !(run && (h < 2));
      evs  = !(run && (v < 1));
      edin = ede ? {4'h0, 8'(v - 2), 12'(h - 4)} : 24'h000000;
      check($sformatf("hs@%0d", n), 32'(vif.video_hsync), 32'(ehs));
      check($sformatf("vs@%0d", n), 32'(vif.video_vsync), 32'(evs));
      check($sformatf("de@%0d", n), 32'(vif.video_de), 32'(ede));
      check($sformatf("din@%0d", n), 32'(vif.video_din), 32'(edin));
   endtask

   initial begin
      int de_cnt, req_cnt, fs_last, ls_last, exp_x, exp_y, fs_cnt, fs_first;
      int ls_first, ls_second, run_len, max_run;
      logic found;

      reset_n = 1'b0;
      enable  = 1'b0;
      en_def  = 1'b0;
      repeat (3) @(negedge pclk);
      check("rst_req",   32'(vif.pixel_req),   32'd0);
      check("rst_fs",    32'(vif.frame_start), 32'd0);
      check("rst_hs",    32'(vif.video_hsync), 32'd1);
      check("rst_vs",    32'(vif.video_vsync), 32'd1);
      check("rst_de",    32'(vif.video_de),    32'd0);
      check("rst_din",   32'(vif.video_din),   32'd0);
      reset_n = 1'b1;
      repeat (3) @(negedge pclk);
      check("idle_hs",   32'(vif.video_hsync), 32'd1);
      check("idle_ls",   32'(vif.line_start),  32'd0);

      // Run 1: enable dropped during frame 1, which must still complete.
      enable = 1'b1;
      de_cnt = 0;
      for (int n = 1; n <= 140; n++) begin
         @(negedge pclk);
         check_cycle(n, 120);
         if (n >= 4 && n < 64 && vif.video_de) de_cnt++;
         if (n == 85) enable = 1'b0;
      end
      check("de_per_frame", 32'(de_cnt), 32'd12);

      // Run 2: three frames, periods and coordinate sequence.
      enable  = 1'b1;
      fs_last = -1;
      ls_last = -1;
      req_cnt = 0;
      exp_x   = 0;
      exp_y   = 0;
      for (int n = 1; n <= 190; n++) begin
         @(negedge pclk);
         check_cycle(n, 180);
         if (vif.frame_start) begin
            if (fs_last >= 0) check("fs_period", 32'(n - fs_last), 32'd60);
            fs_last = n;
         end
         if (vif.line_start) begin
            if (ls_last >= 0) check("ls_period", 32'(n - ls_last), 32'd10);
            ls_last = n;
         end
         if (vif.pixel_req) begin
            check("x_seq", 32'(vif.pixel_x), 32'(exp_x));
            check("y_seq", 32'(vif.pixel_y), 32'(exp_y));
            req_cnt++;
            exp_x++;
            if (exp_x == 4) begin
               exp_x = 0;
               exp_y = (exp_y == 2) ? 0 : exp_y + 1;
            end
         end
         if (n == 150) enable = 1'b0;
      end
      check("req_total", 32'(req_cnt), 32'd36);
      check("fs_last",   32'(fs_last), 32'd122);

      // Run 3: asynchronous reset during an active pixel.
      enable = 1'b1;
      found  = 1'b0;
      for (int n = 1; n <= 60 && !found; n++) begin
         @(negedge pclk);
         if (vif.video_de) found = 1'b1;
      end
      check("de_seen", 32'(found), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("mrst_de",  32'(vif.video_de),    32'd0);
      check("mrst_din", 32'(vif.video_din),   32'd0);
      check("mrst_hs",  32'(vif.video_hsync), 32'd1);
      check("mrst_vs",  32'(vif.video_vsync), 32'd1);
      check("mrst_req", 32'(vif.pixel_req),   32'd0);
      repeat (2) @(negedge pclk);
      reset_n = 1'b1;
      for (int n = 1; n <= 40; n++) begin
         @(negedge pclk);
         check_cycle(n, 1000);
      end
      enable = 1'b0;

      // Default 640x480 timing: first frame through the first active line.
      en_def    = 1'b1;
      fs_cnt    = 0;
      fs_first  = -1;
      ls_first  = -1;
      ls_second = -1;
      req_cnt   = 0;
      de_cnt    = 0;
      run_len   = 0;
      max_run   = 0;
      for (int n = 1; n <= 36 * 800 + 2; n++) begin
         @(negedge pclk);
         if (vif_def.frame_start) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = n;
         end
         if (vif_def.line_start) begin
            if (ls_first < 0)       ls_first = n;
            else if (ls_second < 0) ls_second = n;
         end
         if (vif_def.pixel_req) begin
            req_cnt++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
         end else begin
            run_len = 0;
         end
         if (vif_def.video_de) de_cnt++;
      end
      check("def_fs_first", 32'(fs_first),             32'd2);
      check("def_fs_cnt",   32'(fs_cnt),               32'd1);
      check("def_line_len", 32'(ls_second - ls_first), 32'd800);
      check("def_req_cnt",  32'(req_cnt),              32'd640);
      check("def_req_run",  32'(max_run),              32'd640);
      check("def_de_cnt",   32'(de_cnt),               32'd640);
      en_def = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
